// File: rtl/eth_lpbk_switch.sv
// Loopback switch in front of the MAC tx port: forwards either the oran source
// or the MAC rx stream to tx, switching only on packet boundaries.
module eth_lpbk_switch #(
  parameter int DATA_W     = 64,
  parameter int USER_W     = 31,
  parameter int DROP_UNSEL = 1,
  localparam int KEEP_W    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lpbk_req,
  input  logic [DATA_W-1:0] oran_if_tx_tdata,
  input  logic [KEEP_W-1:0] oran_if_tx_tkeep,
  input  logic              oran_if_tx_tvalid,
  input  logic              oran_if_tx_tlast,
  input  logic [USER_W-1:0] oran_if_tx_tuser,
  output logic              oran_if_tx_tready,
  input  logic [DATA_W-1:0] eth_core_rx_tdata,
  input  logic [KEEP_W-1:0] eth_core_rx_tkeep,
  input  logic              eth_core_rx_tvalid,
  input  logic              eth_core_rx_tlast,
  input  logic [USER_W-1:0] eth_core_rx_tuser,
  output logic              eth_core_rx_tready,
  output logic [DATA_W-1:0] eth_core_tx_tdata,
  output logic [KEEP_W-1:0] eth_core_tx_tkeep,
  output logic              eth_core_tx_tvalid,
  output logic              eth_core_tx_tlast,
  output logic [USER_W-1:0] eth_core_tx_tuser,
  input  logic              eth_core_tx_tready,
  output logic              lpbk_active,
  output logic [31:0]       lpbk_pkt_cnt,
  output logic [31:0]       drop_pkt_cnt
);

  typedef enum logic {NORM = 1'b0, LPBK = 1'b1} state_t;

  state_t            state, state_nxt;
  logic              oran_in_pkt, rx_in_pkt;
  logic              oran_pkt_nxt, rx_pkt_nxt;
  logic              oran_acc, rx_acc;
  logic              vld_p0;
  logic [DATA_W-1:0] tdata_p0;
  logic [KEEP_W-1:0] tkeep_p0;
  logic              tlast_p0;
  logic [USER_W-1:0] tuser_p0;
  logic              skid_vld;
  logic [DATA_W-1:0] skid_tdata;
  logic [KEEP_W-1:0] skid_tkeep;
  logic              skid_tlast;
  logic [USER_W-1:0] skid_tuser;
  logic [31:0]       lpbk_cnt, drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= NORM;
    else     state <= state_nxt;
  end

  // Boundary test uses the in-packet flags as they will be after this cycle's
  // acceptances, so a tlast accepted now lets the switch happen next cycle.
  always_comb begin
    oran_acc     = oran_if_tx_tvalid & oran_if_tx_tready;
    rx_acc       = eth_core_rx_tvalid & eth_core_rx_tready;
    oran_pkt_nxt = oran_acc ? ~oran_if_tx_tlast : oran_in_pkt;
    rx_pkt_nxt   = rx_acc ? ~eth_core_rx_tlast : rx_in_pkt;
    state_nxt    = state;
    if (!oran_pkt_nxt && !rx_pkt_nxt) state_nxt = lpbk_req ? LPBK : NORM;
  end

  always_comb begin
    oran_if_tx_tready  = 1'b0;
    eth_core_rx_tready = 1'b0;
    if (!rst) begin
      if (state == LPBK) begin
        eth_core_rx_tready = ~skid_vld;
      end else begin
        oran_if_tx_tready  = ~skid_vld;
        eth_core_rx_tready = (DROP_UNSEL != 0);
      end
    end
  end

  // p0: selected source beat; rx beats accepted in NORM are dropped here
  always_comb begin
    if (state == LPBK) begin
      vld_p0   = rx_acc;
      tdata_p0 = eth_core_rx_tdata;
      tkeep_p0 = eth_core_rx_tkeep;
      tlast_p0 = eth_core_rx_tlast;
      tuser_p0 = eth_core_rx_tuser;
    end else begin
      vld_p0   = oran_acc;
      tdata_p0 = oran_if_tx_tdata;
      tkeep_p0 = oran_if_tx_tkeep;
      tlast_p0 = oran_if_tx_tlast;
      tuser_p0 = oran_if_tx_tuser;
    end
  end

  // p1: output register backed by a skid register
  always_ff @(posedge clk) begin
    if (rst) begin
      oran_in_pkt        <= 1'b0;
      rx_in_pkt          <= 1'b0;
      lpbk_cnt           <= 32'd0;
      drop_cnt           <= 32'd0;
      skid_vld           <= 1'b0;
      eth_core_tx_tvalid <= 1'b0;
      eth_core_tx_tdata  <= '0;
      eth_core_tx_tkeep  <= '0;
      eth_core_tx_tlast  <= 1'b0;
      eth_core_tx_tuser  <= '0;
    end else begin
      oran_in_pkt <= oran_pkt_nxt;
      rx_in_pkt   <= rx_pkt_nxt;
      if (rx_acc && eth_core_rx_tlast) begin
        if (state == LPBK) lpbk_cnt <= lpbk_cnt + 32'd1;
        else               drop_cnt <= drop_cnt + 32'd1;
      end
      if (!eth_core_tx_tvalid || eth_core_tx_tready) begin
        if (skid_vld) begin
          eth_core_tx_tvalid <= 1'b1;
          eth_core_tx_tdata  <= skid_tdata;
          eth_core_tx_tkeep  <= skid_tkeep;
          eth_core_tx_tlast  <= skid_tlast;
          eth_core_tx_tuser  <= skid_tuser;
          skid_vld           <= 1'b0;
        end else begin
          eth_core_tx_tvalid <= vld_p0;
          if (vld_p0) begin
            eth_core_tx_tdata <= tdata_p0;
            eth_core_tx_tkeep <= tkeep_p0;
            eth_core_tx_tlast <= tlast_p0;
            eth_core_tx_tuser <= tuser_p0;
          end
        end
      end else if (vld_p0) begin
        skid_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (eth_core_tx_tvalid && !eth_core_tx_tready && vld_p0 && !skid_vld) begin
      skid_tdata <= tdata_p0;
      skid_tkeep <= tkeep_p0;
      skid_tlast <= tlast_p0;
      skid_tuser <= tuser_p0;
    end
  end

  assign lpbk_active  = (state == LPBK);
  assign lpbk_pkt_cnt = lpbk_cnt;
  assign drop_pkt_cnt = drop_cnt;

endmodule

// File: tb/tb_eth_lpbk_switch.sv
// Directed bench for eth_lpbk_switch with a tx scoreboard; a second instance
// with DROP_UNSEL=0 shares the inputs to observe the hold behaviour.
module tb_eth_lpbk_switch;

  logic        clk = 1'b0;
  logic        rst, lpbk_req;
  logic [63:0] o_tdata, r_tdata, tx_tdata, h_tdata;
  logic [7:0]  o_tkeep, r_tkeep, tx_tkeep, h_tkeep;
  logic        o_tvalid, o_tlast, o_tready, r_tvalid, r_tlast, r_tready;
  logic [30:0] o_tuser, r_tuser, tx_tuser, h_tuser;
  logic        tx_tvalid, tx_tlast, tx_tready;
  logic        h_tvalid, h_tlast, h_o_tready, h_r_tready, h_active;
  logic        lpbk_active;
  logic [31:0] lpbk_cnt, drop_cnt, h_lpbk_cnt, h_drop_cnt;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [30:0] u;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  eth_lpbk_switch #(.DATA_W(64), .USER_W(31), .DROP_UNSEL(1)) dut (
    .clk(clk), .rst(rst), .lpbk_req(lpbk_req),
    .oran_if_tx_tdata(o_tdata), .oran_if_tx_tkeep(o_tkeep), .oran_if_tx_tvalid(o_tvalid),
    .oran_if_tx_tlast(o_tlast), .oran_if_tx_tuser(o_tuser), .oran_if_tx_tready(o_tready),
    .eth_core_rx_tdata(r_tdata), .eth_core_rx_tkeep(r_tkeep), .eth_core_rx_tvalid(r_tvalid),
    .eth_core_rx_tlast(r_tlast), .eth_core_rx_tuser(r_tuser), .eth_core_rx_tready(r_tready),
    .eth_core_tx_tdata(tx_tdata), .eth_core_tx_tkeep(tx_tkeep), .eth_core_tx_tvalid(tx_tvalid),
    .eth_core_tx_tlast(tx_tlast), .eth_core_tx_tuser(tx_tuser), .eth_core_tx_tready(tx_tready),
    .lpbk_active(lpbk_active), .lpbk_pkt_cnt(lpbk_cnt), .drop_pkt_cnt(drop_cnt)
  );

  eth_lpbk_switch #(.DATA_W(64), .USER_W(31), .DROP_UNSEL(0)) dut_h (
    .clk(clk), .rst(rst), .lpbk_req(lpbk_req),
    .oran_if_tx_tdata(o_tdata), .oran_if_tx_tkeep(o_tkeep), .oran_if_tx_tvalid(o_tvalid),
    .oran_if_tx_tlast(o_tlast), .oran_if_tx_tuser(o_tuser), .oran_if_tx_tready(h_o_tready),
    .eth_core_rx_tdata(r_tdata), .eth_core_rx_tkeep(r_tkeep), .eth_core_rx_tvalid(r_tvalid),
    .eth_core_rx_tlast(r_tlast), .eth_core_rx_tuser(r_tuser), .eth_core_rx_tready(h_r_tready),
    .eth_core_tx_tdata(h_tdata), .eth_core_tx_tkeep(h_tkeep), .eth_core_tx_tvalid(h_tvalid),
    .eth_core_tx_tlast(h_tlast), .eth_core_tx_tuser(h_tuser), .eth_core_tx_tready(tx_tready),
    .lpbk_active(h_active), .lpbk_pkt_cnt(h_lpbk_cnt), .drop_pkt_cnt(h_drop_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard pop and stall-stability check on the tx port
  beat_t prev;
  logic  prev_stall = 1'b0;
  always @(negedge clk) begin
    beat_t cur;
    cur = '{d: tx_tdata, k: tx_tkeep, l: tx_tlast, u: tx_tuser};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("tx_stable", {tx_tvalid, cur}, {1'b1, prev});
      if (tx_tvalid && tx_tready) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL tx_unexpected observed=%0h expected=none", tx_tdata);
        end
        if (exp_q.size() != 0) chk("tx_beat", cur, exp_q.pop_front());
      end
      prev_stall = tx_tvalid && !tx_tready;
      prev       = cur;
    end
  end

  task automatic oran_beat(input logic last, input bit fwd);
    beat_t b;
    int    n = 0;
    b.d = {$urandom, $urandom};
    b.k = last ? 8'h0F : 8'hFF;
    b.l = last;
    b.u = 31'($urandom);
    o_tdata = b.d; o_tkeep = b.k; o_tlast = b.l; o_tuser = b.u; o_tvalid = 1'b1;
    @(negedge clk);
    while (!o_tready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("oran_ready_wait", o_tready, 1'b1);
    if (fwd) exp_q.push_back(b);
    tick();
    o_tvalid = 1'b0;
  endtask

  task automatic rx_beat(input logic last, input bit fwd);
    beat_t b;
    int    n = 0;
    b.d = {$urandom, $urandom};
    b.k = last ? 8'h07 : 8'hFF;
    b.l = last;
    b.u = 31'($urandom);
    r_tdata = b.d; r_tkeep = b.k; r_tlast = b.l; r_tuser = b.u; r_tvalid = 1'b1;
    @(negedge clk);
    while (!r_tready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rx_ready_wait", r_tready, 1'b1);
    if (fwd) exp_q.push_back(b);
    tick();
    r_tvalid = 1'b0;
  endtask

  task automatic oran_pkt(input int n, input bit fwd);
    for (int i = 0; i < n; i++) oran_beat(i == n - 1, fwd);
  endtask

  task automatic rx_pkt(input int n, input bit fwd);
    for (int i = 0; i < n; i++) rx_beat(i == n - 1, fwd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; lpbk_req = 1'b0; tx_tready = 1'b1;
    o_tdata = '0; o_tkeep = '0; o_tvalid = 1'b0; o_tlast = 1'b0; o_tuser = '0;
    r_tdata = '0; r_tkeep = '0; r_tvalid = 1'b1; r_tlast = 1'b0; r_tuser = '0;

    // reset state
    @(negedge clk);
    chk("rst_oran_rdy", o_tready, 1'b0);
    chk("rst_rx_rdy", r_tready, 1'b0);
    tick(); tick();
    chk("rst_tx_vld", tx_tvalid, 1'b0);
    chk("rst_tx_data", {tx_tdata, tx_tkeep, tx_tlast, tx_tuser}, '0);
    chk("rst_active", lpbk_active, 1'b0);
    chk("rst_cnts", {lpbk_cnt, drop_cnt}, 64'd0);
    r_tvalid = 1'b0;
    rst = 1'b0;
    #1;
    chk("norm_rx_rdy_drop", r_tready, 1'b1);
    chk("norm_rx_rdy_hold", h_r_tready, 1'b0);
    chk("norm_oran_rdy", o_tready, 1'b1);

    // normal pass-through, then an rx packet discarded
    oran_pkt(4, 1'b1);
    chk("pt_latency_vld", {tx_tvalid, tx_tlast, tx_tkeep}, {1'b1, 1'b1, 8'h0F});
    tick();
    chk("pt_idle", tx_tvalid, 1'b0);
    rx_pkt(3, 1'b0);
    chk("pt_drop_cnt", drop_cnt, 32'd1);
    chk("pt_lpbk_cnt", lpbk_cnt, 32'd0);

    // deferred switch: request rises on beat 2 of a 5-beat oran packet
    fork
      oran_pkt(5, 1'b1);
      begin
        tick();
        lpbk_req = 1'b1;
        tick(); tick(); tick();
        @(negedge clk);
        chk("defer_active_pre", lpbk_active, 1'b0);
        tick();
        chk("defer_active_post", lpbk_active, 1'b1);
      end
    join
    chk("lpbk_oran_rdy", o_tready, 1'b0);
    rx_pkt(2, 1'b1);
    chk("lpbk_cnt_1", lpbk_cnt, 32'd1);

    // back to NORM, then request while rx is mid-packet
    lpbk_req = 1'b0;
    tick(); tick();
    chk("back_norm", lpbk_active, 1'b0);
    rx_beat(1'b0, 1'b0);
    lpbk_req = 1'b1;
    rx_beat(1'b0, 1'b0);
    rx_beat(1'b0, 1'b0);
    chk("midpkt_wait", lpbk_active, 1'b0);
    rx_beat(1'b1, 1'b0);
    chk("midpkt_switch", lpbk_active, 1'b1);
    chk("midpkt_drop_cnt", drop_cnt, 32'd2);
    rx_pkt(3, 1'b1);
    chk("lpbk_cnt_2", lpbk_cnt, 32'd2);

    // counter wrap
    @(negedge clk);
    force dut.lpbk_cnt = 32'hFFFF_FFFE;
    tick();
    release dut.lpbk_cnt;
    chk("wrap_preset", lpbk_cnt, 32'hFFFF_FFFE);
    rx_pkt(1, 1'b1);
    chk("wrap_max", lpbk_cnt, 32'hFFFF_FFFF);
    rx_pkt(1, 1'b1);
    chk("wrap_zero", lpbk_cnt, 32'd0);

    // backpressure on a 6-beat oran packet
    lpbk_req = 1'b0;
    tick(); tick();
    chk("bp_norm", lpbk_active, 1'b0);
    fork
      oran_pkt(6, 1'b1);
      begin
        tick();
        tx_tready = 1'b1;
        tick();
        tx_tready = 1'b0;
        @(negedge clk);
        chk("bp_rdy_one_stall", o_tready, 1'b1);
        tick();
        @(negedge clk);
        chk("bp_rdy_full", o_tready, 1'b0);
        tick();
        tx_tready = 1'b1;
        @(negedge clk);
        chk("bp_rdy_draining", o_tready, 1'b0);
        tick();
        @(negedge clk);
        chk("bp_rdy_free", o_tready, 1'b1);
      end
    join
    repeat (3) tick();
    chk("bp_sb_empty", exp_q.size(), 0);
    chk("hold_drop_cnt", h_drop_cnt, 32'd0);

    // reset on beat 3 of a loopback packet
    lpbk_req = 1'b1;
    tick(); tick();
    chk("rst2_pre_active", lpbk_active, 1'b1);
    rx_beat(1'b0, 1'b1);
    rx_beat(1'b0, 1'b1);
    r_tdata = 64'h0123_4567_89AB_CDEF; r_tlast = 1'b0; r_tvalid = 1'b1;
    rst = 1'b1;
    lpbk_req = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst2_rx_rdy", r_tready, 1'b0);
    chk("rst2_oran_rdy", o_tready, 1'b0);
    tick();
    chk("rst2_tx_vld", tx_tvalid, 1'b0);
    chk("rst2_cnts", {lpbk_cnt, drop_cnt}, 64'd0);
    chk("rst2_active", lpbk_active, 1'b0);
    rst = 1'b0;
    r_tvalid = 1'b0;
    tick();
    chk("rst2_hold_rx_rdy", h_r_tready, 1'b0);
    chk("rst2_drop_rx_rdy", r_tready, 1'b1);
    oran_pkt(2, 1'b1);
    repeat (3) tick();
    chk("final_sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
